// File: rtl/store_merge_rmw_if.sv
// Store-path bus bundle: request side from EX/MEM plus the word-wide data memory port.
// The slave modport is the store unit's view; master is the pipeline/memory side.
interface store_merge_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              err;

  modport master (
    output req_valid, size, addr, wdata, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, size, addr, wdata, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );
endinterface

// File: rtl/store_merge_rmw.sv
// Store-path unit: partial stores run read-modify-write on a word-only memory port.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned or oversize stores with err.
module store_merge_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  store_merge_rmw_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, TRAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LB-1:0]     lane_q;
  logic [1:0]        es_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [1:0]        es;
  logic [LB-1:0]     low_bits;
  logic [LB-1:0]     align_mask;
  logic [LB-1:0]     lane;
  logic              full;
  logic              trap;
  logic [LANES-1:0]  bmask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] merged;

  // Request decode: clamp size to the word, align the lane to the access size.
  always_comb begin
    es         = (32'(bus.size) > LB) ? 2'(LB) : bus.size;
    low_bits   = bus.addr[LB-1:0];
    align_mask = ~((LB'(1) << es) - LB'(1));
    lane       = low_bits & align_mask;
    full       = (32'(es) == LB);
`ifdef STORE_MISALIGN_TRAP_EN
    trap       = ((low_bits & ~align_mask) != '0) || (32'(bus.size) > LB);
`else
    trap       = 1'b0;
`endif
  end

  // Little-endian lane merge of the registered store data into the returned word.
  always_comb begin
    shifted = wdata_q << {lane_q, 3'b000};
    bmask   = ((LANES'(1) << (LANES'(1) << es_q)) - LANES'(1)) << lane_q;
    merged  = bus.mem_rdata;
    for (int i = 0; i < LANES; i++) begin
      if (bmask[i]) merged[8*i +: 8] = shifted[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lane_q      <= '0;
      es_q        <= '0;
      wdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q     <= lane;
            es_q       <= es;
            wdata_q    <= bus.wdata;
            mem_addr_q <= {bus.addr[ADDR_W-1:LB], LB'(0)};
            if (trap) begin
              state  <= TRAP;
              done_q <= 1'b1;
            end else if (full) begin
              state       <= WRITE;
              mem_wr_q    <= 1'b1;
              done_q      <= 1'b1;
              mem_wdata_q <= bus.wdata;
            end else begin
              state    <= READ;
              mem_rd_q <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WAIT;
          cnt   <= '0;
        end
        // Read data is only valid in the last wait cycle, so merge and write from there.
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state       <= WRITE;
            mem_wr_q    <= 1'b1;
            done_q      <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE:   state <= IDLE;
        TRAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a write caught mid-reset never reaches memory.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.mem_rd    = mem_rd_q && !rst;
  assign bus.mem_wr    = mem_wr_q && !rst;
  assign bus.done      = done_q && !rst;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef STORE_MISALIGN_TRAP_EN
  assign bus.err       = (state == TRAP) && !rst;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: cycle-level reference model with a memory responder,
// plus directed vectors with literal expectations and an RD_LAT=3 instance.
module tb_store_merge_rmw;
  localparam int RD_LAT = 1;
  localparam int NCYC   = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_merge_rmw_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  store_merge_rmw_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

  store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: per-cycle expectations filled in when a request is accepted.
  bit          exp_rd   [NCYC];
  bit          exp_wr   [NCYC];
  bit          exp_done [NCYC];
  bit          exp_err  [NCYC];
  bit          exp_hold [NCYC];
  logic [31:0] exp_addr [NCYC];
  logic [31:0] exp_wdata[NCYC];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] emem [logic [31:0]];
  int          busy_until = -1;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  int          prev_acc_cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic [31:0] last_dut_wdata = '0;
  logic [31:0] last_dut_addr = '0;
  logic [31:0] last_model_wdata = '0;
  logic        last_err = 1'b0;

  int          c;
  int          es_m;
  int          nb_m;
  int          lane_m;
  int          tdone;
  logic [31:0] w_m;
  logic [31:0] waddr_m;
  bit          trap_m;

  int          pend_due = -1;
  logic [31:0] pend_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [31:0] mget(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] eget(input logic [31:0] a);
    return emem.exists(a) ? emem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mmem[a] = v;
    emem[a] = v;
  endtask

  // Memory responder: returns read data exactly RD_LAT cycles after the read strobe.
  always @(posedge clk) begin
    #2;
    if (bus.mem_wr) emem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_rd) begin
      pend_due  = cyc + RD_LAT;
      pend_data = eget(bus.mem_addr);
    end
    bus.mem_rdata = (cyc == pend_due) ? pend_data : (32'hDEAD0000 | 32'(cyc & 16'hFFFF));
  end

  // Compare process and model update, once per cycle away from the clock edge.
  always @(negedge clk) begin
    c = cyc;
    if (rst) begin
      for (int k = c; k < c + 8 && k < NCYC; k++) begin
        exp_rd[k]   = 1'b0;
        exp_wr[k]   = 1'b0;
        exp_done[k] = 1'b0;
        exp_err[k]  = 1'b0;
        exp_hold[k] = 1'b0;
      end
      busy_until = c;
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(!rst && c > busy_until));
    checkOutput("mem_rd", 32'(bus.mem_rd), 32'(exp_rd[c]));
    checkOutput("mem_wr", 32'(bus.mem_wr), 32'(exp_wr[c]));
    checkOutput("done", 32'(bus.done), 32'(exp_done[c]));
    checkOutput("err", 32'(bus.err), 32'(exp_err[c]));
    if (exp_rd[c] || exp_wr[c] || exp_hold[c])
      checkOutput("mem_addr", bus.mem_addr, exp_addr[c]);
    if (exp_wr[c]) begin
      checkOutput("mem_wdata", bus.mem_wdata, exp_wdata[c]);
      mmem[exp_addr[c]] = exp_wdata[c];
      last_model_wdata  = exp_wdata[c];
    end
    if (bus.done) begin
      done_cnt++;
      last_done_cyc  = c;
      last_dut_wdata = bus.mem_wdata;
      last_dut_addr  = bus.mem_addr;
      last_err       = bus.err;
    end
    if (!rst && bus.req_valid && c > busy_until) begin
      es_m    = (bus.size > 2'd2) ? 2 : int'(bus.size);
      nb_m    = 1 << es_m;
      waddr_m = {bus.addr[31:2], 2'b00};
      trap_m  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      trap_m  = ((int'(bus.addr[1:0]) % nb_m) != 0) || (bus.size == 2'd3);
`endif
      prev_acc_cyc = last_acc_cyc;
      last_acc_cyc = c;
      acc_cnt++;
      if (trap_m) begin
        exp_done[c+1] = 1'b1;
        exp_err[c+1]  = 1'b1;
        busy_until    = c + 1;
      end else if (es_m == 2) begin
        exp_wr[c+1]    = 1'b1;
        exp_done[c+1]  = 1'b1;
        exp_addr[c+1]  = waddr_m;
        exp_wdata[c+1] = bus.wdata;
        busy_until     = c + 1;
      end else begin
        lane_m = int'(bus.addr[1:0]) / nb_m * nb_m;
        w_m    = mget(waddr_m);
        for (int i = 0; i < nb_m; i++) w_m[8*(lane_m+i) +: 8] = bus.wdata[8*i +: 8];
        tdone         = c + RD_LAT + 2;
        exp_rd[c+1]   = 1'b1;
        for (int k = c + 1; k <= tdone; k++) begin
          exp_hold[k] = 1'b1;
          exp_addr[k] = waddr_m;
        end
        exp_wr[tdone]    = 1'b1;
        exp_done[tdone]  = 1'b1;
        exp_wdata[tdone] = w_m;
        busy_until       = tdone;
      end
    end
  end

  // Presents a request and holds it until the model has accepted it.
  task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int start;
    start = acc_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.size      = s;
    bus.addr      = a;
    bus.wdata     = d;
    for (int n = 0; n < 50 && acc_cnt == start; n++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("accept", 32'(acc_cnt - start), 32'd1);
  endtask

  task automatic waitIdle();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int n = 0; n < 50 && cyc <= busy_until; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle", 32'(cyc > busy_until), 32'd1);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 50000");
    $fatal(1, "[TB] watchdog expired");
  end

  int d0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.size       = 2'd0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus3.req_valid = 1'b0;
    bus3.size      = 2'd0;
    bus3.addr      = '0;
    bus3.wdata     = '0;
    bus3.mem_rdata = 32'hFFFFFFFF;
    preload(32'h1000, 32'h11223344);
    preload(32'h2000, 32'hCAFEF00D);
    preload(32'h4000, 32'h55555555);
    preload(32'h5000, 32'h89ABCDEF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);

    $display("[TB] byte store 0x1002");
    applyStimulus(2'd0, 32'h1002, 32'h000000AB);
    waitIdle();
    checkOutput("byte_wdata", last_dut_wdata, 32'h11AB3344);
    checkOutput("byte_model", last_model_wdata, 32'h11AB3344);
    checkOutput("byte_addr", last_dut_addr, 32'h1000);
    checkOutput("byte_latency", 32'(last_done_cyc - last_acc_cyc), 32'd3);
    checkOutput("byte_err", 32'(last_err), 32'd0);

    $display("[TB] half store 0x2002 then byte at lane 3");
    applyStimulus(2'd1, 32'h2002, 32'h0000BEEF);
    waitIdle();
    checkOutput("half_wdata", last_dut_wdata, 32'hBEEFF00D);
    checkOutput("half_model", last_model_wdata, 32'hBEEFF00D);
    preload(32'h2000, 32'hCAFEF00D);
    applyStimulus(2'd0, 32'h2003, 32'h0000007F);
    waitIdle();
    checkOutput("lane3_wdata", last_dut_wdata, 32'h7FFEF00D);
    checkOutput("lane3_model", last_model_wdata, 32'h7FFEF00D);

    $display("[TB] word store 0x3000");
    applyStimulus(2'd2, 32'h3000, 32'hDEADBEEF);
    waitIdle();
    checkOutput("word_wdata", last_dut_wdata, 32'hDEADBEEF);
    checkOutput("word_latency", 32'(last_done_cyc - last_acc_cyc), 32'd1);

    $display("[TB] misaligned half 0x1001");
    applyStimulus(2'd1, 32'h1001, 32'h00001234);
    waitIdle();
    checkOutput("mis_latency_pos", 32'(last_done_cyc > last_acc_cyc), 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("mis_err", 32'(last_err), 32'd1);
    checkOutput("mis_latency", 32'(last_done_cyc - last_acc_cyc), 32'd1);
`else
    checkOutput("mis_err", 32'(last_err), 32'd0);
    checkOutput("mis_addr", last_dut_addr, 32'h1000);
    checkOutput("mis_wdata", last_dut_wdata, 32'h11AB1234);
`endif

    $display("[TB] oversize store 0x4002");
    applyStimulus(2'd3, 32'h4002, 32'h01234567);
    waitIdle();
    checkOutput("over_latency", 32'(last_done_cyc - last_acc_cyc), 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("over_err", 32'(last_err), 32'd1);
`else
    checkOutput("over_wdata", last_dut_wdata, 32'h01234567);
    checkOutput("over_addr", last_dut_addr, 32'h4000);
`endif

    $display("[TB] reset during wait");
    d0 = done_cnt;
    applyStimulus(2'd0, 32'h5001, 32'h00000066);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(bus.req_ready), 32'd1);
    repeat (4) @(posedge clk);
    checkOutput("rst_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("rst_no_write", eget(32'h5000), 32'h89ABCDEF);

    $display("[TB] back-to-back byte stores");
    applyStimulus(2'd0, 32'h1000, 32'h00000001);
    applyStimulus(2'd0, 32'h1003, 32'h00000002);
    waitIdle();
    checkOutput("b2b_gap", 32'(last_acc_cyc - prev_acc_cyc), 32'd4);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("b2b_wdata", last_dut_wdata, 32'h02AB3301);
`else
    checkOutput("b2b_wdata", last_dut_wdata, 32'h02AB1201);
`endif

    $display("[TB] half store with upper data bits set");
    applyStimulus(2'd1, 32'h5000, 32'hFFFFA5A5);
    waitIdle();
    checkOutput("half_lo_wdata", last_dut_wdata, 32'h89ABA5A5);

    $display("[TB] RD_LAT=3 instance byte store");
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b1;
    bus3.size      = 2'd0;
    bus3.addr      = 32'h1002;
    bus3.wdata     = 32'h000000AB;
    @(negedge clk);
    checkOutput("l3_ready_t0", 32'(bus3.req_ready), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      bus3.req_valid = 1'b0;
      bus3.mem_rdata = (k == 4) ? 32'h11223344 : 32'hFFFFFFFF;
      @(negedge clk);
      checkOutput("l3_mem_rd", 32'(bus3.mem_rd), 32'(k == 1));
      checkOutput("l3_mem_wr", 32'(bus3.mem_wr), 32'(k == 5));
      checkOutput("l3_done", 32'(bus3.done), 32'(k == 5));
      checkOutput("l3_ready", 32'(bus3.req_ready), 32'(k == 6));
      if (k <= 5) checkOutput("l3_mem_addr", bus3.mem_addr, 32'h1000);
      if (k == 5) checkOutput("l3_wdata", bus3.mem_wdata, 32'h11AB3344);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Parametrised store-path unit between the EX/MEM pipeline stage and data memory.
- Executes byte, halfword and full-word stores on a memory port that only writes whole words.
- Partial stores use a read-modify-write sequence: read the old word, merge the new lanes, write the word back.
- Full-width stores write directly. Supersedes the single-cycle combinational byte-store merge.

Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8, power of two, >=16.
- ADDR_W, 32, byte-address width.
- RD_LAT, 1, memory read latency in cycles (>=1): mem_rdata is valid RD_LAT cycles after the mem_rd cycle.
- Derived: LANES=DATA_W/8, LB=log2(LANES).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle, can accept a request.
- size  in  2  log2 of store bytes: 0 byte, 1 half, 2 word, 3 dword.
- addr  in  ADDR_W  byte address of the store.
- wdata  in  DATA_W  store data, right-justified (low bits used).
- mem_addr  out  ADDR_W  word-aligned address, low LB bits = 0.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  read data.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  merged write word.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done (feature only).

Behaviour:
- Reset: state IDLE; mem_rd=0, mem_wr=0, done=0, err=0, mem_addr=0, mem_wdata=0. req_ready is 0 while rst=1.
- req_ready=1 only in IDLE with rst=0. Accept occurs on req_valid&&req_ready (cycle T0); addr, size and wdata are registered at T0.
- Effective size: es = min(size, LB); a size above LB clamps to full width (feature off).
- Lane index: L = addr[LB-1:0], with the low es bits forced to 0 (alignment).
- Layout is little-endian. Byte i of the stored data goes to mem bits 8*(L+i)+7 : 8*(L+i), for i < 2^es.
- Full-width store (es==LB): at T1, state WRITE; mem_wr=1, mem_wdata=wdata, done=1. Return to IDLE; req_ready=1 at T2.
- Partial store:
  - T1, state READ: mem_rd=1, mem_addr=aligned addr.
  - State WAIT: lasts RD_LAT cycles; mem_rdata is captured in the last WAIT cycle (T1+RD_LAT).
  - State WRITE at T1+RD_LAT+1: mem_wr=1, mem_addr unchanged, done=1.
  - mem_wdata = captured word with only the selected lanes replaced.
  - Total latency from accept to done is RD_LAT+2 cycles.
- mem_addr is held stable from READ through WRITE. mem_rd and mem_wr are never both high.
- req_valid is ignored outside IDLE; there is no queuing, and upstream stalls on req_ready=0.
- rst in any state: abort immediately, return to IDLE, no write, no done. A write already in progress that cycle is suppressed (mem_wr forced 0 while rst=1).
- Back-to-back: a new request can be accepted in the cycle after done.

Optional Feature:
- STORE_MISALIGN_TRAP_EN defined:
  - A store with addr[es-1:0] != 0, or size > LB, is rejected.
  - At T1: done=1, err=1, no mem_rd and no mem_wr; return to IDLE.
- Undefined: err is tied 0; low address bits are silently truncated and an oversize request clamps to full width, as described above.

Test Plan (DATA_W=32, RD_LAT=1):
- Byte store: addr=0x1002, size=0, wdata=0xAB, mem word 0x11223344 -> T1 mem_rd at 0x1000; T3 mem_wr, mem_wdata=0x11AB3344, done=1.
- Half store: addr=0x2002, size=1, wdata=0xBEEF, mem 0xCAFEF00D -> T3 mem_wdata=0xBEEFF00D; byte at lane 3 via addr=0x2003, wdata=0x7F -> 0x7FFEF00D.
- Word store: addr=0x3000, size=2, wdata=0xDEADBEEF -> no mem_rd; T1 mem_wr, mem_wdata=0xDEADBEEF, done=1; req_ready=1 at T2.
- Reset during WAIT: rst=1 at T2 of a byte store -> mem_wr never asserted, done stays 0, req_ready=1 the cycle after rst falls.
- Misaligned half addr=0x1001, size=1: feature on -> T1 done=1, err=1, no memory strobes; feature off -> mem_addr=0x1000, lanes 0-1 written.
- Back-to-back: two byte stores with req_valid held high -> second accepted the cycle after the first done; RD_LAT=3 build gives done at T5.
